// File: rtl/rr_thermo_arbiter_if.sv
// Request/grant bundle for rr_thermo_arbiter.
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface rr_thermo_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
`ifdef RR_ARB_LOCK_EN
    logic          lock;
`endif
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;

    modport master (
`ifdef RR_ARB_LOCK_EN
        output lock,
`endif
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
`ifdef RR_ARB_LOCK_EN
        input  lock,
`endif
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx
    );
endinterface

// File: rtl/rr_thermo_arbiter.sv
// Round-robin arbiter over a thermometer priority mask with bounded grant hold.
// Define RR_ARB_LOCK_EN to add the lock input that pins the current owner.
module rr_thermo_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 1
) (
    input logic               clk,
    input logic               rst,
    rr_thermo_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0]  ONE      = N'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;

    logic [N-1:0]  mask;
    logic [N-1:0]  masked;
    logic [IW-1:0] win_idx;
    logic          any_req;
    logic          owner_req;
    logic          any_other;
    logic          lock_hold;
    logic          keep_owner;
    logic          do_grant;
    logic          do_idle;

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = owner_req & bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Winner: lowest request above the last owner, else wrap to the lowest request overall.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IW'(i) > last);
        end
        masked  = bus.req & mask;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) win_idx = IW'(i);
        end
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        any_req    = |bus.req;
        owner_req  = |(bus.req & gnt_q);
        any_other  = |(bus.req & ~gnt_q);
        keep_owner = lock_hold || !any_other || (hold_cnt < HOLD_MAX);
        do_grant   = 1'b0;
        do_idle    = 1'b0;
        if (state == IDLE) begin
            do_grant = any_req;
        end else if (!owner_req) begin
            do_grant = any_req;
            do_idle  = !any_req;
        end else begin
            do_grant = !keep_owner;
        end
    end

    // gnt_idx and last survive a return to IDLE so the rotation point is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= LAST_RST;
            hold_cnt <= '0;
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else if (do_grant) begin
            state    <= GRANT;
            last     <= win_idx;
            hold_cnt <= HW'(1);
            gnt_q    <= ONE << win_idx;
            idx_q    <= win_idx;
            valid_q  <= 1'b1;
        end else if (do_idle) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
        end else if (state == GRANT && hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
endmodule

// File: tb/tb_rr_thermo_arbiter.sv
// Directed bench for rr_thermo_arbiter: three instances with MAX_HOLD 2, 1 and 4.
// Lock vectors run only when RR_ARB_LOCK_EN is defined.
module tb_rr_thermo_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_thermo_arbiter_if #(.N(4)) if2 ();
    rr_thermo_arbiter_if #(.N(4)) if1 ();
    rr_thermo_arbiter_if #(.N(4)) if4 ();

    rr_thermo_arbiter #(.N(4), .MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    rr_thermo_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    rr_thermo_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive every input, then advance one edge and settle before outputs are sampled.
    task automatic applyStimulus(input logic rst_v, input logic [3:0] r2, input logic [3:0] r1,
                                 input logic [3:0] r4, input logic lk);
        rst     = rst_v;
        if2.req = r2;
        if1.req = r1;
        if4.req = r4;
`ifdef RR_ARB_LOCK_EN
        if1.lock = lk;
        if2.lock = 1'b0;
        if4.lock = 1'b0;
`else
        if (lk) $display("[TB] lock requested but feature not built");
`endif
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rot [9];

    initial begin
        rot = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001};

        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        checkOutput("rst_gnt",   32'(if2.gnt), 32'h0);
        checkOutput("rst_valid", 32'(if2.gnt_valid), 32'h0);
        checkOutput("rst_idx",   32'(if2.gnt_idx), 32'h0);
        checkOutput("rst_gnt4",  32'(if4.gnt), 32'h0);

        // Rotation with MAX_HOLD=2; first entry is the grant one edge after reset release.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
            checkOutput($sformatf("rot%0d", k), 32'(if2.gnt), 32'(rot[k]));
        end
        checkOutput("rot_valid", 32'(if2.gnt_valid), 32'h1);
        checkOutput("rot_idx",   32'(if2.gnt_idx), 32'h0);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0100, 4'b0000, 1'b0);
            checkOutput($sformatf("lone%0d", k), 32'(if1.gnt), 32'h4);
        end
        checkOutput("lone_idx", 32'(if1.gnt_idx), 32'h2);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        checkOutput("lone_drop_gnt",   32'(if1.gnt), 32'h0);
        checkOutput("lone_drop_valid", 32'(if1.gnt_valid), 32'h0);
        checkOutput("lone_drop_idx",   32'(if1.gnt_idx), 32'h2);

        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0);
        checkOutput("er_own1", 32'(if4.gnt), 32'h2);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b1011, 1'b0);
        checkOutput("er_hold", 32'(if4.gnt), 32'h2);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b1001, 1'b0);
        checkOutput("er_rel",  32'(if4.gnt), 32'h8);
        checkOutput("er_idx3", 32'(if4.gnt_idx), 32'h3);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0110, 1'b0);
        checkOutput("er_wrap", 32'(if4.gnt), 32'h2);
        checkOutput("er_wrap_idx", 32'(if4.gnt_idx), 32'h1);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0);
        checkOutput("mid_pre", 32'(if4.gnt), 32'h4);

        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        checkOutput("mid_rst_gnt",   32'(if4.gnt), 32'h0);
        checkOutput("mid_rst_valid", 32'(if4.gnt_valid), 32'h0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        checkOutput("mid_after", 32'(if4.gnt), 32'h1);
        checkOutput("mid_after_valid", 32'(if4.gnt_valid), 32'h1);

`ifdef RR_ARB_LOCK_EN
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b1);
            checkOutput($sformatf("lock%0d", k), 32'(if1.gnt), 32'h1);
        end
        applyStimulus(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b0);
        checkOutput("lock_drop", 32'(if1.gnt), 32'h2);
`else
        applyStimulus(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b0);
        checkOutput("pair0", 32'(if1.gnt), 32'h1);
        applyStimulus(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b0);
        checkOutput("pair1", 32'(if1.gnt), 32'h2);
        applyStimulus(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b0);
        checkOutput("pair2", 32'(if1.gnt), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_thermo_arbiter.md
# rr_thermo_arbiter

Parametrised round-robin arbiter built on a thermometer priority mask: N requesters and a registered one-hot grant. The grant rotates fairly from the last winner. Each grant can be held for a bounded number of cycles, and is released early when the owner drops its request. The block sits between the request sources and a shared resource (bus, memory port, FIFO write side). It is the next generation of the team's `thermometer_priority_mask`, which is combinational only.

## Interface
Parameters:
- `N`, default 4, number of requesters (≥2).
- `MAX_HOLD`, default 1, maximum consecutive cycles a grant is held while other requesters wait (≥1; 1 = pure per-cycle round-robin).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high; sampled on the `clk` rising edge.
- `req`  in  N  request vector; bit i = requester i wants the resource.
- `lock`  in  1  hold request from the current owner (present only with `RR_ARB_LOCK_EN`).
- `gnt`  out  N  registered one-hot grant, or all-zero.
- `gnt_valid`  out  1  high when `gnt` is nonzero.
- `gnt_idx`  out  $clog2(N)  binary index of the granted requester; holds the last owner while `gnt_valid`=0.

## Operation
- State: `IDLE` (no grant) and `GRANT` (one owner), `last` pointer ($clog2(N) bits), `hold_cnt` ($clog2(MAX_HOLD+1) bits).
- Thermometer mask: `mask[i]=1` for every i > `last`, else 0.
- Winner: the lowest set bit of `req & mask` if that is nonzero; otherwise the lowest set bit of `req`. This wraps past N-1 to 0.
- `IDLE`: if `req`≠0, move to `GRANT` with owner = winner, `last` = winner, `hold_cnt`=1. Otherwise stay in `IDLE`.
- `GRANT`, owner's req bit low: the owner releases. In the same edge, re-arbitrate as from `IDLE`, with no bubble cycle. If `req`=0, go to `IDLE`.
- `GRANT`, owner's req still high, `hold_cnt` < MAX_HOLD: keep the owner and increment `hold_cnt`.
- `GRANT`, owner's req still high, `hold_cnt` = MAX_HOLD:
  - If any other req bit is set, rotate to the winner, with `last` = owner's index before the update, and set `hold_cnt`=1.
  - If no other request is pending, keep the owner; `hold_cnt` saturates at MAX_HOLD.
- `gnt_valid` = (state == `GRANT`). `gnt` is the one-hot of the owner; `gnt_idx` is the owner index.
- `gnt` is never more than one-hot and never grants a requester whose req bit was low at the sampling edge.

## Timing
- Reset values: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, state `IDLE`, `last`=N-1 (so the empty mask gives requester 0 first priority), `hold_cnt`=0.
- `rst` has priority over all other inputs. Reset mid-grant clears the grant at the same edge.
- Latency: `req` sampled at edge t gives `gnt` valid after edge t+1 (1 cycle). Release to next grant is also 1 cycle.
- Outputs are purely registered; there is no combinational path from `req` to `gnt`.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - Adds the `lock` port.
  - While the owner's req and `lock` are both high, the grant is kept regardless of `hold_cnt`, and `hold_cnt` saturates.
  - When `lock` drops, normal MAX_HOLD rules resume from the saturated count, so rotation happens on the next edge if others are waiting.
- Not defined: there is no `lock` port, and behaviour is exactly as in Operation.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `req`=1111 → `gnt`=0000, `gnt_valid`=0, `gnt_idx`=0. Then release `rst` → `gnt`=0001 one edge later.
- Rotation, N=4, MAX_HOLD=2: `req`=1111 held → `gnt` sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
- Lone requester, MAX_HOLD=1: `req`=0100 for 6 cycles → `gnt`=0100 on every cycle. Drop `req` to 0000 → next edge `gnt`=0000, `gnt_valid`=0, `gnt_idx`=2.
- Early release and wrap, MAX_HOLD=4:
  - Owner 1 active, `req` changes from 1011 to 1001 → next edge `gnt`=1000.
  - Then with owner 3, `req` changes to 0110 → next edge `gnt`=0010 (wrap via the unmasked fallback).
- Mid-operation reset: `gnt`=0100, assert `rst` for one edge with `req`=1111 → `gnt`=0000. One edge after `rst` drops → `gnt`=0001.
- Lock (`RR_ARB_LOCK_EN`, MAX_HOLD=1):
  - Owner 0, `req`=0011, `lock`=1 for 5 cycles → `gnt`=0001 throughout.
  - Drop `lock` → next edge `gnt`=0010.
